// File: rtl/param_seq_shifter_pkg.sv
// ============================================================================
// Module  : param_seq_shifter_pkg
// Brief   : Shift-mode codes and FSM state encodings for param_seq_shifter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package param_seq_shifter_pkg;

    typedef enum logic [1:0] {
        MODE_LSR = 2'b00,
        MODE_LSL = 2'b01,
        MODE_ASR = 2'b10,
        MODE_ROR = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

`default_nettype wire

// File: rtl/param_seq_shifter_shift_step.sv
// ============================================================================
// Module  : shift_step
// Brief   : Combinational shift of up to STEP positions; reports the last bit out.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module shift_step
    import param_seq_shifter_pkg::*;
#(
    parameter int N    = 4,
    parameter int STEP = 1,
    parameter int KW   = $clog2(STEP + 1)
) (
    input  logic [N-1:0]  data,
    input  mode_e         mode,
    input  logic [KW-1:0] k,
    output logic [N-1:0]  shifted,
    output logic          carry
);

    logic [N-1:0] w_d;
    logic         w_c;

    // Unrolled single-bit steps keep the carry equal to the bit leaving last.
    always_comb begin
        w_d = data;
        w_c = 1'b0;
        for (int j = 0; j < STEP; j++) begin
            if (KW'(j) < k) begin
                case (mode)
                    MODE_LSL: begin
                        w_c = w_d[N-1];
                        w_d = {w_d[N-2:0], 1'b0};
                    end
                    MODE_ASR: begin
                        w_c = w_d[0];
                        w_d = {w_d[N-1], w_d[N-1:1]};
                    end
                    MODE_ROR: begin
                        w_c = w_d[0];
                        w_d = {w_d[0], w_d[N-1:1]};
                    end
                    default: begin
                        w_c = w_d[0];
                        w_d = {1'b0, w_d[N-1:1]};
                    end
                endcase
            end
        end
    end

    assign shifted = w_d;
    assign carry   = w_c;

endmodule

`default_nettype wire

// File: rtl/param_seq_shifter.sv
// ============================================================================
// Module  : param_seq_shifter
// Brief   : Multi-cycle LSR/LSL/ASR/ROR shifter with start/busy/done handshake.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module param_seq_shifter
    import param_seq_shifter_pkg::*;
#(
    parameter  int N    = 4,
    parameter  int STEP = 1,
    localparam int AW   = $clog2(N),
    localparam int KW   = $clog2(STEP + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          en,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic [AW-1:0] amount,
    input  logic [N-1:0]  data_in,
    output logic [N-1:0]  data_out,
    output logic          carry_out,
    output logic          busy,
    output logic          done
);

    localparam logic [AW-1:0] c_STEP = AW'(STEP);

    state_e        r_state;
    state_e        w_state_next;
    logic [N-1:0]  r_data;
    logic          r_carry;
    logic [AW-1:0] r_cnt;
    mode_e         r_mode;
    logic          r_busy;
    logic          r_done;

    logic          w_accept;
    logic [KW-1:0] w_k;
    logic [AW-1:0] w_cnt_next;
    logic [N-1:0]  w_shifted;
    logic          w_carry;

    assign w_accept   = start && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_k        = (r_cnt > c_STEP) ? KW'(STEP) : r_cnt[KW-1:0];
    assign w_cnt_next = r_cnt - AW'(w_k);

    shift_step #(
        .N    (N),
        .STEP (STEP),
        .KW   (KW)
    ) u_shift_step (
        .data    (r_data),
        .mode    (r_mode),
        .k       (w_k),
        .shifted (w_shifted),
        .carry   (w_carry)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_next = (amount != '0) ? ST_SHIFT : ST_DONE;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (en && w_cnt_next == '0) begin
                    w_state_next = ST_DONE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // busy/done are registered copies of the next-state decode.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next == ST_SHIFT);
            r_done  <= (w_state_next == ST_DONE);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_data  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_mode  <= MODE_LSR;
        end else if (w_accept) begin
            r_data  <= data_in;
            r_carry <= 1'b0;
            r_cnt   <= amount;
            r_mode  <= mode_e'(mode);
        end else if (r_state == ST_SHIFT && en) begin
            r_data  <= w_shifted;
            r_carry <= w_carry;
            r_cnt   <= w_cnt_next;
        end
    end

    assign data_out  = r_data;
    assign carry_out = r_carry;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

`default_nettype wire
